// File: rtl/lfsr_rr_scheduler.sv
// Round-robin scheduler sharing one external lfsr64 among NREQ requesters.
// Optional lockup detection/recovery is compiled in with `define LFSR_LOCKUP_DETECT_EN.
module lfsr_rr_scheduler #(
  parameter int          NREQ         = 4,
  parameter int          OUT_W        = 16,
  parameter int          STEPS        = 8,
  parameter int          WARMUP       = 4,
  parameter logic [63:0] DEFAULT_SEED = 64'h0123456789ABCDEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reseed,
  input  logic [63:0]      seed_in,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_data,
  output logic             busy,
  output logic             lfsr_run,
  output logic             lfsr_load,
  output logic [63:0]      lfsr_seed,
  input  logic [63:0]      lfsr_q,
  output logic             lockup_err
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (STEPS > WARMUP) ? STEPS : WARMUP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {INIT, LOAD, WARM, IDLE, STEP, DELIVER} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [63:0]      seed_reg, pend_seed;
  logic             pend;
  logic [PW-1:0]    ptr, gidx, pick;
  logic             found;
  logic [OUT_W-1:0] data_reg;
  logic             lockup_hit;
  logic             seed_req;
  logic             grant_active;

  assign seed_req     = reseed | pend;
  assign grant_active = (gnt != '0);

`ifdef LFSR_LOCKUP_DETECT_EN
  // The xnor LFSR never leaves all-ones, so treat it as a fault while shifting.
  assign lockup_hit = ((state == WARM) || (state == STEP)) && (lfsr_q == '1);
`else
  logic unused_lfsr_bits;
  assign lockup_hit       = 1'b0;
  assign unused_lfsr_bits = ^lfsr_q;
`endif

  // First requester at or after ptr, wrapping around.
  always_comb begin
    logic [PW-1:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT: state_next = LOAD;
      LOAD: begin
        if (WARMUP == 0) state_next = grant_active ? STEP : IDLE;
        else             state_next = WARM;
      end
      WARM: begin
        if (lockup_hit)                      state_next = LOAD;
        else if (cnt == CW'(WARMUP - 1))     state_next = grant_active ? STEP : IDLE;
      end
      IDLE: begin
        if (seed_req)   state_next = LOAD;
        else if (found) state_next = STEP;
      end
      STEP: begin
        if (lockup_hit)                  state_next = LOAD;
        else if (cnt == CW'(STEPS - 1))  state_next = DELIVER;
      end
      DELIVER: state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_next;
  end

  // Counter restarts whenever WARM/STEP is entered, including re-entry after a lockup reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      seed_reg  <= DEFAULT_SEED;
      pend      <= 1'b0;
      pend_seed <= '0;
      gnt       <= '0;
      gidx      <= '0;
      ptr       <= '0;
      data_reg  <= '0;
    end else begin
      if (((state == WARM) || (state == STEP)) && (state_next == state))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;

      if (state == IDLE) begin
        if (reseed) begin
          seed_reg <= seed_in;
          pend     <= 1'b0;
        end else if (pend) begin
          seed_reg <= pend_seed;
          pend     <= 1'b0;
        end else if (found) begin
          gnt  <= NREQ'(1) << pick;
          gidx <= pick;
        end
      end else if (reseed) begin
        pend      <= 1'b1;
        pend_seed <= seed_in;
      end

      if (lockup_hit)
        seed_reg <= DEFAULT_SEED;

      if (state == DELIVER) begin
        gnt      <= '0;
        data_reg <= lfsr_q[OUT_W-1:0];
        ptr      <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

`ifdef LFSR_LOCKUP_DETECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            lockup_err <= 1'b0;
    else if (lockup_hit)                   lockup_err <= 1'b1;
    else if ((state == IDLE) && seed_req)  lockup_err <= 1'b0;
  end
`else
  assign lockup_err = 1'b0;
`endif

  assign lfsr_load = (state == LOAD);
  assign lfsr_run  = (state == WARM) || (state == STEP);
  assign lfsr_seed = seed_reg;
  assign rnd_valid = (state == DELIVER);
  assign busy      = (state != IDLE);
  // The word is forwarded straight from the LFSR during the pulse, then held.
  assign rnd_data  = (state == DELIVER) ? lfsr_q[OUT_W-1:0] : data_reg;

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Self-checking bench for lfsr_rr_scheduler with a behavioural lfsr64 and reference model.
module tb_lfsr_rr_scheduler;

  localparam int          NREQ   = 4;
  localparam int          OUT_W  = 16;
  localparam int          STEPS  = 8;
  localparam int          WARMUP = 4;
  localparam logic [63:0] DSEED  = 64'h0123456789ABCDEF;
  localparam logic [63:0] PSEED  = 64'h0F1E2D3C4B5A6978;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             reseed = 1'b0;
  logic [63:0]      seed_in = '0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  gnt;
  logic             rnd_valid;
  logic [OUT_W-1:0] rnd_data;
  logic             busy;
  logic             lfsr_run;
  logic             lfsr_load;
  logic [63:0]      lfsr_seed;
  logic [63:0]      env_q = '0;
  logic             lockup_err;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          mptr = 0;
  int          last_valid_cyc = 0;
  int          prev_valid_cyc = 0;
  logic [63:0] mstate = '0;

  lfsr_rr_scheduler #(
    .NREQ(NREQ), .OUT_W(OUT_W), .STEPS(STEPS), .WARMUP(WARMUP), .DEFAULT_SEED(DSEED)
  ) dut (
    .clk(clk), .reset(reset), .reseed(reseed), .seed_in(seed_in), .req(req),
    .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .busy(busy),
    .lfsr_run(lfsr_run), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
    .lfsr_q(env_q), .lockup_err(lockup_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
  endfunction

  function automatic logic [63:0] advance(input logic [63:0] s, input int n);
    logic [63:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = lfsr_next(t);
    return t;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  // External lfsr64 datapath driven by the scheduler's load/run pins.
  always @(posedge clk) begin
    if (lfsr_load)     env_q <= lfsr_seed;
    else if (lfsr_run) env_q <= lfsr_next(env_q);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Seed load followed by warm-up, ending in the first IDLE cycle.
  task automatic bootSeq(input logic [63:0] seed);
    tick();
    reseed = 1'b0;
    checkOutput("load_pulse", lfsr_load, 1'b1);
    checkOutput("load_norun", lfsr_run, 1'b0);
    checkOutput("load_seed", lfsr_seed, seed);
    for (int i = 0; i < WARMUP; i++) begin
      tick();
      checkOutput("warm_run", lfsr_run, 1'b1);
      checkOutput("warm_noload", lfsr_load, 1'b0);
      checkOutput("warm_nognt", gnt, '0);
    end
    tick();
    checkOutput("boot_idle_busy", busy, 1'b0);
    checkOutput("boot_idle_run", lfsr_run, 1'b0);
    mstate = advance(seed, WARMUP);
  endtask

  // mode: 0 drop req after, 1 keep req, 2 drop req mid-transaction, 3 inject two reseeds
  task automatic applyStimulus(input logic [NREQ-1:0] r, input int mode);
    int              idx;
    logic [NREQ-1:0] oh;
    idx    = rr_pick(r, mptr);
    oh     = NREQ'(1) << idx;
    mstate = advance(mstate, STEPS);
    req    = r;
    tick();
    for (int c = 1; c <= STEPS + 1; c++) begin
      checkOutput("gnt", gnt, oh);
      checkOutput("rnd_valid", rnd_valid, (c == STEPS + 1));
      if (c == STEPS + 1) begin
        checkOutput("rnd_data", rnd_data, mstate[OUT_W-1:0]);
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      if (mode == 2 && c == 3) req = '0;
      if (mode == 3 && c == 2) begin reseed = 1'b1; seed_in = 64'hA5A5A5A55A5A5A5A; end
      if (mode == 3 && c == 4) begin reseed = 1'b1; seed_in = PSEED; end
      if (mode == 3 && (c == 3 || c == 5)) reseed = 1'b0;
      if (c <= STEPS) tick();
    end
    if (mode != 1) req = '0;
    tick();
    checkOutput("post_busy", busy, 1'b0);
    checkOutput("post_gnt", gnt, '0);
    checkOutput("hold_data", rnd_data, mstate[OUT_W-1:0]);
    mptr = (idx + 1) % NREQ;
  endtask

  initial begin
    int rv;
    // Reset state
    tick();
    checkOutput("rst_gnt", gnt, '0);
    checkOutput("rst_valid", rnd_valid, 1'b0);
    checkOutput("rst_data", rnd_data, '0);
    checkOutput("rst_run", lfsr_run, 1'b0);
    checkOutput("rst_load", lfsr_load, 1'b0);
    checkOutput("rst_busy", busy, 1'b1);
    checkOutput("rst_lockup", lockup_err, 1'b0);
    reset = 1'b1;
    bootSeq(DSEED);

    // Single transaction on requester 2
    applyStimulus(4'b0100, 0);

    // Reset in the third STEP cycle aborts asynchronously
    req = 4'b0100;
    tick();
    tick();
    tick();
    checkOutput("pre_abort_gnt", gnt, 4'b0100);
    checkOutput("pre_abort_run", lfsr_run, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("abort_gnt", gnt, '0);
    checkOutput("abort_run", lfsr_run, 1'b0);
    checkOutput("abort_valid", rnd_valid, 1'b0);
    checkOutput("abort_busy", busy, 1'b1);
    req = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("in_reset_valid", rnd_valid, 1'b0);
    end
    reset = 1'b1;
    mptr  = 0;
    bootSeq(DSEED);

    // All requesters held: grants rotate 0,1,2,3,0 every STEPS+2 cycles
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 1);
      if (k > 0) checkOutput("spacing", 64'(last_valid_cyc - prev_valid_cyc), 64'(STEPS + 2));
    end
    req = '0;
    tick();

    // Reseed and request in the same IDLE cycle: reseed wins, then grant 0
    reseed  = 1'b1;
    seed_in = 64'h1;
    req     = 4'b0001;
    bootSeq(64'h1);
    applyStimulus(4'b0001, 0);

    // Reseeds during a transaction are pended; the later one wins
    applyStimulus(4'b0010, 3);
    bootSeq(PSEED);

    // Dropping req mid-transaction does not abort it
    applyStimulus(4'b1000, 2);

    // Random request patterns
    for (int k = 0; k < 6; k++) begin
      rv = int'($urandom_range(1, 15));
      applyStimulus(NREQ'(rv), 0);
    end

`ifdef LFSR_LOCKUP_DETECT_EN
    reseed  = 1'b1;
    seed_in = '1;
    tick();
    reseed = 1'b0;
    tick();
    tick();
    checkOutput("lockup_reload", lfsr_load, 1'b1);
    checkOutput("lockup_seed", lfsr_seed, DSEED);
    checkOutput("lockup_flag", lockup_err, 1'b1);
    for (int i = 0; i < WARMUP; i++) tick();
    tick();
    checkOutput("lockup_idle", busy, 1'b0);
    mstate = advance(DSEED, WARMUP);
    applyStimulus(4'b0010, 0);
    checkOutput("lockup_sticky", lockup_err, 1'b1);
`else
    // Without detection an all-ones seed stays stuck
    reseed  = 1'b1;
    seed_in = '1;
    bootSeq('1);
    applyStimulus(4'b0010, 0);
    applyStimulus(4'b0100, 0);
    checkOutput("no_lockup_flag", lockup_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
